mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported 32-bit memory.
// Each accepted access runs IDLE -> ACCESS -> (WAIT) -> RESP before the next request is sampled.
module mem_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int MEM_WORDS    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [1:0]  LAT_M1 = 2'(READ_LATENCY - 1);
   localparam logic [29:0] WORDS  = 30'(MEM_WORDS);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic        rej_q, rej_d;
   logic        owner_q, owner_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  ack_q, ack_d;
   logic [1:0]  err_q, err_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        busy_q, busy_d;

   logic        win;
   logic        sel_we;
   logic        sel_rej;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   // Next-state and next-output logic; every output is the registered copy of its _d value.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      rej_d       = rej_q;
      owner_d     = owner_q;
      gnt_d       = 2'b00;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      win         = 1'b0;
      sel_we      = 1'b0;
      sel_addr    = 32'h0000_0000;
      sel_wdata   = 32'h0000_0000;

      // Under contention the master that did not win last time goes first.
      if (m0_req && m1_req) begin
         win = ~owner_q;
      end else if (m1_req) begin
         win = 1'b1;
      end else begin
         win = 1'b0;
      end

      if (win) begin
         sel_we    = m1_we;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
      end else begin
         sel_we    = m0_we;
         sel_addr  = m0_addr;
         sel_wdata = m0_wdata;
      end
      sel_rej = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= WORDS);

      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               state_d     = ACCESS;
               owner_d     = win;
               we_d        = sel_we;
               rej_d       = sel_rej;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               gnt_d[win]  = 1'b1;
               mem_en_d    = ~sel_rej;
               mem_we_d    = ~sel_rej & sel_we;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (rej_q || we_q) begin
               state_d        = RESP;
               ack_d[owner_q] = 1'b1;
               err_d[owner_q] = rej_q;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_M1;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d        = RESP;
               ack_d[owner_q] = 1'b1;
               if (owner_q) begin
                  rdata1_d = mem_rdata;
               end else begin
                  rdata0_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         we_q        <= 1'b0;
         rej_q       <= 1'b0;
         owner_q     <= 1'b1;
         gnt_q       <= 2'b00;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         rdata0_q    <= 32'h0000_0000;
         rdata1_q    <= 32'h0000_0000;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         rej_q       <= rej_d;
         owner_q     <= owner_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         busy_q      <= busy_d;
      end
   end

   assign m0_gnt    = gnt_q[0];
   assign m1_gnt    = gnt_q[1];
   assign m0_ack    = ack_q[0];
   assign m1_ack    = ack_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule
